// File: rtl/exe_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between issue ports 0 and 1.
// Latency: request sampled at t -> div_en_in at t+1; div_en_out at d -> reqN_done at d+1.
// Backpressure: requests are held (reqN_stall) until their done pulse; one op in flight.
module exe_div_arbiter #(
   parameter int TIMEOUT = 48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_by_writeback,
   input  logic        req0_valid,
   input  logic        req0_op,
   input  logic        req0_sign,
   input  logic [31:0] req0_sr0,
   input  logic [31:0] req0_sr1,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_pc,
   input  logic [31:0] req0_inst,
   input  logic        req1_valid,
   input  logic        req1_op,
   input  logic        req1_sign,
   input  logic [31:0] req1_sr0,
   input  logic [31:0] req1_sr1,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_pc,
   input  logic [31:0] req1_inst,
   output logic        req0_done,
   output logic        req0_stall,
   output logic        req1_done,
   output logic        req1_stall,
   output logic [31:0] res_result,
   output logic [4:0]  res_addr,
   output logic [31:0] res_pc,
   output logic [31:0] res_inst,
   output logic        div_en_in,
   output logic        div_op,
   output logic        div_sign,
   output logic [31:0] div_sr0,
   output logic [31:0] div_sr1,
   output logic [31:0] div_pc_in,
   output logic [31:0] div_inst_in,
   output logic [4:0]  div_addr_in,
   output logic        div_flush,
   input  logic        div_en_out,
   input  logic [31:0] div_result,
   input  logic [4:0]  div_addr_out,
   input  logic [31:0] div_pc_out,
   input  logic [31:0] div_inst_out,
   output logic        timeout_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   logic [1:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic              op_q, op_d;
   logic              sign_q, sign_d;
   logic [31:0]       sr0_q, sr0_d;
   logic [31:0]       sr1_q, sr1_d;
   // addr/pc/inst hold the request tag until ISSUE, then the divider's echo once it completes
   logic [4:0]        addr_q, addr_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       result_q, result_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d;
   logic              timeout_err_q, timeout_err_d;
   logic              dropped_q, dropped_d;

   logic              owner_valid;
   logic              grant_sel;
   logic              timeout_fire;
   logic              done_pulse;
   logic              issue;

   assign owner_valid = owner_q ? req1_valid : req0_valid;

   // Next-state: arbitration, issue, completion/watchdog wait, result return; flush overrides all
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      owner_d       = owner_q;
      op_d          = op_q;
      sign_d        = sign_q;
      sr0_d         = sr0_q;
      sr1_d         = sr1_q;
      addr_d        = addr_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      result_d      = result_q;
      wdog_d        = wdog_q;
      timeout_err_d = timeout_err_q;
      dropped_d     = dropped_q;
      timeout_fire  = 1'b0;
      grant_sel     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               // a lone requester wins; on contention the port not served last wins
               grant_sel = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
               owner_d   = grant_sel;
               op_d      = grant_sel ? req1_op   : req0_op;
               sign_d    = grant_sel ? req1_sign : req0_sign;
               sr0_d     = grant_sel ? req1_sr0  : req0_sr0;
               sr1_d     = grant_sel ? req1_sr1  : req0_sr1;
               addr_d    = grant_sel ? req1_addr : req0_addr;
               pc_d      = grant_sel ? req1_pc   : req0_pc;
               inst_d    = grant_sel ? req1_inst : req0_inst;
               dropped_d = 1'b0;
               wdog_d    = '0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            dropped_d = dropped_q | ~owner_valid;
            wdog_d    = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            dropped_d = dropped_q | ~owner_valid;
            if (div_en_out) begin
               result_d = div_result;
               addr_d   = div_addr_out;
               pc_d     = div_pc_out;
               inst_d   = div_inst_out;
               state_d  = S_DONE;
            end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
               // hung divider: flush it and return a zero result with the original tag
               timeout_fire  = 1'b1;
               timeout_err_d = 1'b1;
               result_d      = '0;
               state_d       = S_DONE;
            end else begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
         S_DONE: begin
            last_grant_d = owner_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush_by_writeback) begin
         state_d       = S_IDLE;
         last_grant_d  = last_grant_q;
         wdog_d        = '0;
         dropped_d     = 1'b0;
         timeout_fire  = 1'b0;
         timeout_err_d = timeout_err_q;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         last_grant_q  <= 1'b1;
         owner_q       <= 1'b0;
         op_q          <= 1'b0;
         sign_q        <= 1'b0;
         sr0_q         <= '0;
         sr1_q         <= '0;
         addr_q        <= '0;
         pc_q          <= '0;
         inst_q        <= '0;
         result_q      <= '0;
         wdog_q        <= '0;
         timeout_err_q <= 1'b0;
         dropped_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         owner_q       <= owner_d;
         op_q          <= op_d;
         sign_q        <= sign_d;
         sr0_q         <= sr0_d;
         sr1_q         <= sr1_d;
         addr_q        <= addr_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         result_q      <= result_d;
         wdog_q        <= wdog_d;
         timeout_err_q <= timeout_err_d;
         dropped_q     <= dropped_d;
      end
   end

   // Outputs: done only to a still-waiting owner, all data buses zero when not in use
   always_comb begin
      issue       = (state_q == S_ISSUE);
      done_pulse  = (state_q == S_DONE) & ~dropped_q & owner_valid & ~flush_by_writeback;
      req0_done   = done_pulse & ~owner_q;
      req1_done   = done_pulse & owner_q;
      req0_stall  = req0_valid & ~req0_done;
      req1_stall  = req1_valid & ~req1_done;
      res_result  = done_pulse ? result_q : '0;
      res_addr    = done_pulse ? addr_q   : '0;
      res_pc      = done_pulse ? pc_q     : '0;
      res_inst    = done_pulse ? inst_q   : '0;
      div_en_in   = issue & ~flush_by_writeback;
      div_op      = issue & op_q;
      div_sign    = issue & sign_q;
      div_sr0     = issue ? sr0_q  : '0;
      div_sr1     = issue ? sr1_q  : '0;
      div_pc_in   = issue ? pc_q   : '0;
      div_inst_in = issue ? inst_q : '0;
      div_addr_in = issue ? addr_q : '0;
      div_flush   = flush_by_writeback | timeout_fire;
      timeout_err = timeout_err_q;
   end

endmodule

// File: tb/tb_exe_div_arbiter.sv
// Bench for exe_div_arbiter: directed vector table, flush/watchdog/drop sequences,
// then randomized two-port traffic checked against arithmetic and fairness rules.
// A behavioural divider with programmable latency answers the DUT's start pulses.
module tb_exe_div_arbiter;

   logic clk, rst, flush_by_writeback;
   logic rq_valid[2], rq_op[2], rq_sign[2];
   logic [31:0] rq_sr0[2], rq_sr1[2], rq_pc[2], rq_inst[2];
   logic [4:0]  rq_addr[2];
   logic req0_done, req0_stall, req1_done, req1_stall;
   logic [31:0] res_result, res_pc, res_inst;
   logic [4:0]  res_addr;
   logic div_en_in, div_op, div_sign, div_flush, div_en_out, timeout_err;
   logic [31:0] div_sr0, div_sr1, div_pc_in, div_inst_in, div_result, div_pc_out, div_inst_out;
   logic [4:0]  div_addr_in, div_addr_out;

   exe_div_arbiter #(.TIMEOUT(48)) dut (
      .clk(clk), .rst(rst), .flush_by_writeback(flush_by_writeback),
      .req0_valid(rq_valid[0]), .req0_op(rq_op[0]), .req0_sign(rq_sign[0]),
      .req0_sr0(rq_sr0[0]), .req0_sr1(rq_sr1[0]), .req0_addr(rq_addr[0]),
      .req0_pc(rq_pc[0]), .req0_inst(rq_inst[0]),
      .req1_valid(rq_valid[1]), .req1_op(rq_op[1]), .req1_sign(rq_sign[1]),
      .req1_sr0(rq_sr0[1]), .req1_sr1(rq_sr1[1]), .req1_addr(rq_addr[1]),
      .req1_pc(rq_pc[1]), .req1_inst(rq_inst[1]),
      .req0_done(req0_done), .req0_stall(req0_stall),
      .req1_done(req1_done), .req1_stall(req1_stall),
      .res_result(res_result), .res_addr(res_addr), .res_pc(res_pc), .res_inst(res_inst),
      .div_en_in(div_en_in), .div_op(div_op), .div_sign(div_sign),
      .div_sr0(div_sr0), .div_sr1(div_sr1), .div_pc_in(div_pc_in), .div_inst_in(div_inst_in),
      .div_addr_in(div_addr_in), .div_flush(div_flush),
      .div_en_out(div_en_out), .div_result(div_result), .div_addr_out(div_addr_out),
      .div_pc_out(div_pc_out), .div_inst_out(div_inst_out),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0, n_en_in = 0, n_done0 = 0, n_done1 = 0, n_dflush = 0;

   function automatic logic [31:0] ref_div(input logic op, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op ? a : 32'hFFFF_FFFF;
      if (sgn) return op ? 32'(sa % sb) : 32'(sa / sb);
      return op ? (a % b) : (a / b);
   endfunction

   // behavioural divider: answers dv_lat cycles after div_en_in unless hung or flushed
   int dv_lat = 8, dv_cnt;
   logic dv_hang = 1'b0, dv_pend;
   logic [31:0] dv_r;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         dv_pend <= 1'b0; div_en_out <= 1'b0; dv_cnt <= 0; dv_r <= '0;
         div_addr_out <= '0; div_pc_out <= '0; div_inst_out <= '0;
      end else begin
         div_en_out <= 1'b0;
         if (div_flush) dv_pend <= 1'b0;
         else if (div_en_in) begin
            dv_pend <= 1'b1;
            dv_cnt <= dv_lat - 1;
            dv_r <= ref_div(div_op, div_sign, div_sr0, div_sr1);
            div_addr_out <= div_addr_in;
            div_pc_out <= div_pc_in;
            div_inst_out <= div_inst_in;
         end else if (dv_pend && !dv_hang) begin
            if (dv_cnt <= 1) begin div_en_out <= 1'b1; dv_pend <= 1'b0; end
            else dv_cnt <= dv_cnt - 1;
         end
      end
   end
   assign div_result = div_en_out ? dv_r : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // advance one cycle, sample #1 after the edge, check per-cycle invariants
   task automatic tick();
      @(posedge clk);
      #1;
      chk("stall0", 32'(req0_stall), 32'(rq_valid[0] & ~req0_done));
      chk("stall1", 32'(req1_stall), 32'(rq_valid[1] & ~req1_done));
      chk("one_done", 32'(req0_done & req1_done), 32'd0);
      if (!(req0_done || req1_done))
         chk("res_idle_zero", res_result | res_pc | res_inst | 32'(res_addr), 32'd0);
      if (!div_en_in && !flush_by_writeback)
         chk("div_idle_zero", div_sr0 | div_sr1 | div_pc_in | div_inst_in | 32'(div_addr_in), 32'd0);
      n_en_in  += int'(div_en_in);
      n_done0  += int'(req0_done);
      n_done1  += int'(req1_done);
      n_dflush += int'(div_flush);
   endtask

   task automatic set_req(input int p, input logic op, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] ad,
                          input logic [31:0] pc, input logic [31:0] inst);
      rq_op[p] = op; rq_sign[p] = sgn; rq_sr0[p] = a; rq_sr1[p] = b;
      rq_addr[p] = ad; rq_pc[p] = pc; rq_inst[p] = inst; rq_valid[p] = 1'b1;
   endtask

   int wd_port, wd_cyc;
   logic [31:0] wd_res, wd_pc, wd_inst;
   logic [4:0] wd_addr;
   task automatic wait_done(input int maxc);
      wd_port = -1; wd_cyc = 0;
      for (int k = 1; k <= maxc; k++) begin
         tick();
         if (req0_done || req1_done) begin
            wd_port = req1_done ? 1 : 0; wd_cyc = k;
            wd_res = res_result; wd_addr = res_addr; wd_pc = res_pc; wd_inst = res_inst;
            return;
         end
      end
      chk("wait_done_timeout", 32'd1, 32'd0);
   endtask

   typedef struct {
      logic op; logic sgn; logic [31:0] a; logic [31:0] b; logic [31:0] exp;
   } vec_t;
   vec_t vt[9];

   int d0, d1, e0, fl_k, dn_k, nr;
   int issued[2], served[2], gap[2], waitc[2], odone[2];
   logic [31:0] e_res[2], e_pc[2], e_inst[2], ra, rb;
   logic [4:0] e_addr[2];
   logic dn, abort;

   initial begin
      #900000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b0, 1'b0, 32'd100, 32'd7, 32'd14};
      vt[1] = '{1'b1, 1'b0, 32'd100, 32'd7, 32'd2};
      vt[2] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD};
      vt[3] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF};
      vt[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF};
      vt[5] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0};
      vt[6] = '{1'b1, 1'b0, 32'd35, 32'd5, 32'd0};
      vt[7] = '{1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2};
      vt[8] = '{1'b1, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2};
      for (int p = 0; p < 2; p++) begin
         rq_valid[p] = 0; rq_op[p] = 0; rq_sign[p] = 0; rq_sr0[p] = 0; rq_sr1[p] = 0;
         rq_addr[p] = 0; rq_pc[p] = 0; rq_inst[p] = 0;
      end
      flush_by_writeback = 1'b0;
      rst = 1'b1;

      // reset state, with both ports already requesting
      set_req(0, 1'b1, 1'b0, 32'd100, 32'd7, 5'd3, 32'h1000, 32'hA0);
      set_req(1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'h2000, 32'hB0);
      tick(); tick();
      chk("rst_done0", 32'(req0_done), 32'd0);
      chk("rst_stall0", 32'(req0_stall), 32'd1);
      chk("rst_div_en_in", 32'(div_en_in), 32'd0);
      chk("rst_div_flush", 32'(div_flush), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst = 1'b0;

      // simultaneous requests: port 0 first, then port 1, then port 0 again
      dv_lat = 8;
      wait_done(100);
      chk("sim1_port", 32'(wd_port), 32'd0);
      chk("sim1_lat", 32'(wd_cyc), 32'd10);
      chk("sim1_res", wd_res, 32'd2);
      chk("sim1_addr", 32'(wd_addr), 32'd3);
      rq_valid[0] = 1'b0;
      wait_done(100);
      chk("sim2_port", 32'(wd_port), 32'd1);
      chk("sim2_res", wd_res, 32'hFFFF_FFFD);
      chk("sim2_pc", wd_pc, 32'h2000);
      rq_valid[1] = 1'b0;
      set_req(0, 1'b0, 1'b0, 32'd100, 32'd7, 5'd5, 32'h3000, 32'hC0);
      set_req(1, 1'b1, 1'b0, 32'd35, 32'd5, 5'd6, 32'h4000, 32'hD0);
      wait_done(100);
      chk("sim3_port", 32'(wd_port), 32'd0);
      chk("sim3_res", wd_res, 32'd14);
      rq_valid[0] = 1'b0;
      wait_done(100);
      chk("sim4_port", 32'(wd_port), 32'd1);
      rq_valid[1] = 1'b0;
      tick();

      // single request: one start pulse, exact latency, tag echo, no done on other port
      dv_lat = 10; e0 = n_en_in; d1 = n_done1;
      set_req(0, 1'b0, 1'b0, 32'd100, 32'd7, 5'd9, 32'h5000, 32'hE0);
      wait_done(100);
      chk("single_port", 32'(wd_port), 32'd0);
      chk("single_lat", 32'(wd_cyc), 32'd12);
      chk("single_res", wd_res, 32'd14);
      chk("single_addr", 32'(wd_addr), 32'd9);
      chk("single_inst", wd_inst, 32'hE0);
      chk("single_en_pulses", 32'(n_en_in - e0), 32'd1);
      chk("single_no_done1", 32'(n_done1 - d1), 32'd0);
      rq_valid[0] = 1'b0;

      // vector table, alternating ports
      for (int i = 0; i < 9; i++) begin
         dv_lat = 2 + 4 * i;
         set_req(i % 2, vt[i].op, vt[i].sgn, vt[i].a, vt[i].b, 5'(i + 10), 32'(i), 32'(i * 3));
         wait_done(100);
         chk("vec_port", 32'(wd_port), 32'(i % 2));
         chk("vec_res", wd_res, vt[i].exp);
         chk("vec_addr", 32'(wd_addr), 32'(i + 10));
         rq_valid[i % 2] = 1'b0;
      end

      // flush during WAIT: combinational div_flush, no done, back to IDLE
      dv_lat = 20;
      set_req(0, 1'b0, 1'b0, 32'd50, 32'd5, 5'd1, 32'h10, 32'h11);
      repeat (4) tick();
      flush_by_writeback = 1'b1;
      #1;
      chk("flush_div_flush", 32'(div_flush), 32'd1);
      d0 = n_done0 + n_done1; e0 = n_en_in;
      tick();
      flush_by_writeback = 1'b0; rq_valid[0] = 1'b0;
      repeat (30) tick();
      chk("flush_no_done", 32'(n_done0 + n_done1 - d0), 32'd0);
      chk("flush_no_issue", 32'(n_en_in - e0), 32'd0);
      dv_lat = 5;
      set_req(1, 1'b0, 1'b0, 32'd50, 32'd5, 5'd2, 32'h20, 32'h21);
      wait_done(100);
      chk("post_flush_port", 32'(wd_port), 32'd1);
      chk("post_flush_lat", 32'(wd_cyc), 32'd7);
      chk("post_flush_res", wd_res, 32'd10);
      rq_valid[1] = 1'b0;

      // flush in the same cycle as div_en_out: result dropped
      dv_lat = 6;
      set_req(0, 1'b0, 1'b0, 32'd9, 32'd3, 5'd7, 32'h30, 32'h31);
      fl_k = 0;
      for (int k = 0; k < 20 && !div_en_out; k++) tick();
      chk("coinc_saw_en_out", 32'(div_en_out), 32'd1);
      flush_by_writeback = 1'b1;
      #1;
      chk("coinc_div_flush", 32'(div_flush), 32'd1);
      d0 = n_done0 + n_done1;
      tick();
      flush_by_writeback = 1'b0; rq_valid[0] = 1'b0;
      repeat (5) tick();
      chk("coinc_no_done", 32'(n_done0 + n_done1 - d0), 32'd0);

      // watchdog: divider never answers
      dv_hang = 1'b1; fl_k = -1; dn_k = -1; e0 = n_dflush;
      chk("wd_err_before", 32'(timeout_err), 32'd0);
      set_req(1, 1'b0, 1'b0, 32'd77, 32'd7, 5'd21, 32'h40, 32'h41);
      for (int k = 1; k <= 60 && dn_k < 0; k++) begin
         tick();
         if (div_flush && fl_k < 0) fl_k = k;
         if (req1_done) begin
            dn_k = k; wd_res = res_result; wd_addr = res_addr; wd_pc = res_pc;
            chk("wd_err_at_done", 32'(timeout_err), 32'd1);
         end
      end
      chk("wd_flush_cycle", 32'(fl_k), 32'd49);
      chk("wd_done_cycle", 32'(dn_k), 32'd50);
      chk("wd_res", wd_res, 32'd0);
      chk("wd_addr", 32'(wd_addr), 32'd21);
      chk("wd_pc", wd_pc, 32'h40);
      chk("wd_flush_pulses", 32'(n_dflush - e0), 32'd1);
      rq_valid[1] = 1'b0; dv_hang = 1'b0;
      repeat (3) tick();
      chk("wd_err_sticky", 32'(timeout_err), 32'd1);

      // owner drops valid during WAIT: no done, other port served next
      dv_lat = 15;
      set_req(0, 1'b0, 1'b0, 32'd64, 32'd8, 5'd12, 32'h50, 32'h51);
      tick();
      set_req(1, 1'b0, 1'b0, 32'd100, 32'd7, 5'd13, 32'h60, 32'h61);
      repeat (3) tick();
      rq_valid[0] = 1'b0;
      d0 = n_done0;
      wait_done(150);
      chk("drop_port", 32'(wd_port), 32'd1);
      chk("drop_res", wd_res, 32'd14);
      chk("drop_addr", 32'(wd_addr), 32'd13);
      chk("drop_no_done0", 32'(n_done0 - d0), 32'd0);
      rq_valid[1] = 1'b0;
      tick();

      // randomized two-port traffic
      nr = 40; abort = 1'b0;
      for (int p = 0; p < 2; p++) begin
         issued[p] = 0; served[p] = 0; gap[p] = 0; waitc[p] = 0; odone[p] = 0;
      end
      for (int c = 0; !abort && (served[0] < nr || served[1] < nr); c++) begin
         tick();
         if (c > 20000) begin
            chk("rand_cycle_budget", 32'd1, 32'd0);
            abort = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            dn = (p == 0) ? req0_done : req1_done;
            if (rq_valid[p] && dn) begin
               chk("rand_res", res_result, e_res[p]);
               chk("rand_addr", 32'(res_addr), 32'(e_addr[p]));
               chk("rand_pc", res_pc, e_pc[p]);
               chk("rand_inst", res_inst, e_inst[p]);
               served[p]++;
               rq_valid[p] = 1'b0;
               gap[p] = int'($urandom_range(0, 3));
               if (rq_valid[1 - p]) begin
                  odone[1 - p]++;
                  chk("rand_fairness", 32'(odone[1 - p] <= 1), 32'd1);
               end
            end else if (rq_valid[p]) begin
               waitc[p]++;
               if (waitc[p] > 400) begin
                  chk("rand_req_timeout", 32'd1, 32'd0);
                  abort = 1'b1;
               end
            end else if (gap[p] > 0) begin
               gap[p]--;
            end else if (issued[p] < nr) begin
               ra = $urandom;
               rb = $urandom >> $urandom_range(0, 31);
               if (rb == 32'd0) rb = 32'd1;
               set_req(p, 1'($urandom), 1'($urandom), ra, rb, 5'($urandom), $urandom, $urandom);
               if (rq_sign[p] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rq_sr1[p] = 32'd3;
               e_res[p] = ref_div(rq_op[p], rq_sign[p], rq_sr0[p], rq_sr1[p]);
               e_addr[p] = rq_addr[p]; e_pc[p] = rq_pc[p]; e_inst[p] = rq_inst[p];
               issued[p]++; waitc[p] = 0; odone[p] = 0;
            end
         end
         dv_lat = int'($urandom_range(2, 37));
      end
      chk("rand_served0", 32'(served[0]), 32'(nr));
      chk("rand_served1", 32'(served[1]), 32'(nr));

      // sticky error survives traffic, cleared only by reset
      chk("err_still_set", 32'(timeout_err), 32'd1);
      rst = 1'b1;
      #1;
      chk("err_cleared_by_rst", 32'(timeout_err), 32'd0);
      tick();
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
